x_mem_play: RTL and testbench

//   Playback reader for the 2048x6 sample memory. Issues sequential read addresses
//   to the memory port and returns samples on a valid/ready stream toward the DAC

---
 rtl/x_mem_play_pkg.sv | 29 ++
 rtl/x_mem_play_fifo.sv | 73 +++++++
 rtl/x_mem_play.sv | 200 ++++++++++++++++++++
 tb/tb_x_mem_play.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_play_pkg.sv
// ============================================================================
// Module      : x_mem_play_pkg
// Description : Shared constants and state encoding for the sample-memory
//               playback reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package x_mem_play_pkg;

  localparam int ADDR_W  = 11;   // 2048-entry sample memory
  localparam int DATA_W  = 6;    // sample width
  localparam int MEM_LAT = 3;    // address-to-data latency of the memory
  localparam int FIFO_D  = 4;    // return FIFO depth (>= MEM_LAT+1 for full rate)

  localparam int CNT_W   = $clog2(FIFO_D + 1);           // FIFO occupancy width
  localparam int INF_W   = $clog2(MEM_LAT + 1);          // in-flight read count width
  localparam int CRD_W   = $clog2(FIFO_D + MEM_LAT + 1); // committed-slot sum width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/x_mem_play_fifo.sv
// ============================================================================
// Module      : x_mem_play_fifo
// Description : Small synchronous FIFO catching memory read returns.
//               Clear has priority over push/pop; push into a full FIFO and
//               pop from an empty FIFO are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_mem_play_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNTW-1:0]  count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count < CNTW'(DEPTH));
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNTW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/x_mem_play.sv
// ============================================================================
// Module      : x_mem_play
// Description : Playback reader for the 2048x6 sample memory. Issues
//               sequential reads 0..last (one-shot or looped), absorbs the
//               fixed memory latency in a credit-managed return FIFO and
//               streams samples out on valid/ready. Supports abort.
//               Optional macro X_MEM_PLAY_RATE_EN adds i_div, limiting reads
//               to one per (i_div+1) cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_mem_play
  import x_mem_play_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_nrst,
`ifdef X_MEM_PLAY_RATE_EN
  input  logic [7:0]        i_div,
`endif
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   last_q;
  logic                loop_q;
  logic [MEM_LAT-1:0]  sr;          // one bit per cycle of memory latency
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rdata;
  logic [CRD_W-1:0]    committed;
  logic                credit_ok;
  logic                rate_ok;
  logic                can_issue;
  logic                issue;
  logic                load;
  logic                flush_go;
  logic                to_idle;
  logic                push;
  logic                pop;

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + INF_W'(sr[i]);
    end
  end

  // A slot freed by this cycle's pop can be reused immediately; without this
  // the credit would stall every other cycle at FIFO_D == MEM_LAT+1.
  assign committed = CRD_W'(fifo_count) + CRD_W'(inflight) - CRD_W'(pop);
  assign credit_ok = (committed < CRD_W'(FIFO_D));
  assign can_issue = credit_ok && rate_ok;

`ifdef X_MEM_PLAY_RATE_EN
  logic [7:0] rate_cnt;
  assign rate_ok = (rate_cnt == 8'd0);

  // Pacing counter: reloads on start and on every issue, then counts down.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rate_cnt <= 8'd0;
    end else if (load || issue) begin
      rate_cnt <= i_div;
    end else if (rate_cnt != 8'd0) begin
      rate_cnt <= rate_cnt - 8'd1;
    end
  end
`else
  assign rate_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; stop beats issue in RUN.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load      = 1'b0;
    flush_go  = 1'b0;
    to_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && !i_stop) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          flush_go  = 1'b1;
          state_nxt = FLUSH;
        end else if (can_issue) begin
          issue = 1'b1;
          if ((addr == last_q) && !loop_q) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (i_stop) begin
          flush_go  = 1'b1;
          state_nxt = FLUSH;
        end else if ((inflight == '0) && fifo_empty) begin
          to_idle   = 1'b1;
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (inflight == '0) begin
          to_idle   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address counter plus run parameters captured at start.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      addr   <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
    end else if (load) begin
      addr   <= '0;
      last_q <= i_last;
      loop_q <= i_loop;
    end else if (issue) begin
      if (addr == last_q) begin
        if (loop_q) begin
          addr <= '0;
        end
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Latency tracker and registered done pulse.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sr     <= '0;
      o_done <= 1'b0;
    end else begin
      sr     <= {sr[MEM_LAT-2:0], issue};
      o_done <= to_idle;
    end
  end

  // Returning data is dropped while aborting; the FIFO is emptied on entry.
  assign push       = sr[MEM_LAT-1] && (state != FLUSH) && !flush_go;
  assign o_valid    = !fifo_empty && (state != FLUSH);
  assign pop        = o_valid && i_ready;
  assign o_data     = o_valid ? fifo_rdata : '0;
  assign o_mem_addr = addr;
  assign o_busy     = (state != IDLE);

  x_mem_play_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (DATA_W),
    .CNTW  (CNT_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .clear (flush_go),
    .push  (push),
    .wdata (i_mem_rdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_x_mem_play.sv
// ============================================================================
// Module      : tb_x_mem_play
// Description : Self-checking bench for x_mem_play. Memory is a 3-stage
//               registered array holding mem[a] = a[5:0]; accepted samples
//               are scored against a queue built from the address sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_mem_play;
  import x_mem_play_pkg::*;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              done;
`ifdef X_MEM_PLAY_RATE_EN
  logic [7:0]        div;
`endif

  always #5 clk = ~clk;

  x_mem_play u_dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
`ifdef X_MEM_PLAY_RATE_EN
    .i_div       (div),
`endif
    .i_start     (start),
    .i_stop      (stop),
    .i_loop      (loop),
    .i_last      (last),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Memory model: address register, array read, output register.
  logic [DATA_W-1:0] mem [0:2047];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_arr;
  always @(posedge clk) begin
    m_addr    <= mem_addr;
    m_arr     <= mem[m_addr];
    mem_rdata <= m_arr;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc, stop_cyc, done_cyc, done_cnt, max_cnt;
  int acc_cyc[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor at the falling edge: scoreboard every accepted sample.
  always @(negedge clk) begin
    cyc++;
    if (nrst) begin
      if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
      if (start) start_cyc = cyc;
      if (stop) stop_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid && ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("extra_sample", 1, 0);
        else check("sample", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_run();
    acc_cyc.delete();
    exp_q.delete();
    done_cnt = 0;
    max_cnt  = 0;
  endtask

  // Reference: n samples of the pass sequence 0..lst repeated, value = addr[5:0].
  task automatic fill_exp(input int lst, input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'(i % (lst + 1));
      exp_q.push_back(a[DATA_W-1:0]);
    end
  endtask

  task automatic pulse_start(input int lst, input logic lp);
    last  = ADDR_W'(lst);
    loop  = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    if (done_cnt == 0) check(tag, 0, 1);
  endtask

  initial begin
    logic [ADDR_W-1:0] av;
    int k;
    int n_before;
    for (int a = 0; a < 2048; a++) begin
      av = ADDR_W'(a);
      mem[a] = av[DATA_W-1:0];
    end
    nrst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; last = '0; ready = 1'b1;
`ifdef X_MEM_PLAY_RATE_EN
    div = 8'd0;
`endif
    clear_run();
    step(3);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", data, 0);
    nrst = 1'b1;
    step(2);

    // 1: one-shot 0..7 at full rate
    clear_run(); fill_exp(7, 8); ready = 1'b1;
    pulse_start(7, 1'b0);
    wait_done("t1_done_timeout", 60);
    step(5);
    check("t1_count", acc_cyc.size(), 8);
    if (acc_cyc.size() >= 8) begin
      check("t1_latency", acc_cyc[0] - start_cyc, MEM_LAT + 2);
      check("t1_back2back", acc_cyc[7] - acc_cyc[0], 7);
    end
    check("t1_done_once", done_cnt, 1);
    check("t1_busy", busy, 0);
    check("t1_leftover", exp_q.size(), 0);

    // 2: looped 0..3, 20 samples without gaps, then abort
    clear_run(); fill_exp(3, 60);
    pulse_start(3, 1'b1);
    k = 0;
    while (acc_cyc.size() < 20 && k < 100) begin
      step();
      k++;
    end
    check("t2_got20", acc_cyc.size() >= 20, 1);
    if (acc_cyc.size() >= 20) check("t2_no_gaps", acc_cyc[19] - acc_cyc[0], 19);
    stop = 1'b1; step(); stop = 1'b0;
    wait_done("t2_done_timeout", 20);
    check("t2_done_once", done_cnt, 1);

    // 3: random backpressure, one-shot 0..15
    clear_run(); fill_exp(15, 16);
    pulse_start(15, 1'b0);
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    ready = 1'b1;
    check("t3_done", done_cnt, 1);
    check("t3_count", acc_cyc.size(), 16);
    check("t3_leftover", exp_q.size(), 0);
    check("t3_fifo_bound", max_cnt <= FIFO_D, 1);

    // 4a: stop two cycles after start
    clear_run(); fill_exp(100, 101); ready = 1'b1;
    pulse_start(100, 1'b0);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    check("t4_valid_after_stop", valid, 0);
    wait_done("t4_done_timeout", 10);
    check("t4_done_latency", (done_cyc - stop_cyc) <= MEM_LAT + 1, 1);
    step(3);
    check("t4_dropped", acc_cyc.size(), 0);
    check("t4_done_once", done_cnt, 1);

    // 4b: stop with a full FIFO; only the stop-cycle pop may be delivered
    clear_run(); fill_exp(100, 101); ready = 1'b0;
    pulse_start(100, 1'b0);
    step(8);
    ready = 1'b1; stop = 1'b1; step(); stop = 1'b0;
    check("t4b_valid_after_stop", valid, 0);
    wait_done("t4b_done_timeout", 10);
    step(3);
    check("t4b_flushed", acc_cyc.size(), 1);
    check("t4b_busy", busy, 0);

    // 4c: replay from 0 after an abort
    clear_run(); fill_exp(2, 3);
    pulse_start(2, 1'b0);
    wait_done("t4c_done_timeout", 40);
    step(2);
    check("t4c_count", acc_cyc.size(), 3);
    check("t4c_leftover", exp_q.size(), 0);

    // 5a: last = 0 plays exactly one sample
    clear_run(); fill_exp(0, 1);
    pulse_start(0, 1'b0);
    wait_done("t5a_done_timeout", 30);
    step(3);
    check("t5a_count", acc_cyc.size(), 1);
    check("t5a_done_once", done_cnt, 1);

    // 5b: start and stop together in IDLE do nothing
    clear_run();
    last = ADDR_W'(5); start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("t5b_busy", busy, 0);
    step(10);
    check("t5b_count", acc_cyc.size(), 0);
    check("t5b_no_done", done_cnt, 0);

    // Reset mid-operation: immediate return to reset state, no done
    clear_run(); fill_exp(50, 200);
    pulse_start(50, 1'b1);
    step(10);
    nrst = 1'b0;
    #1;
    check("rst_mid_valid", valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", mem_addr, 0);
    step(2);
    nrst = 1'b1;
    step(5);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", busy, 0);

`ifdef X_MEM_PLAY_RATE_EN
    // 6: paced playback, one sample every 4 cycles
    clear_run(); fill_exp(5, 6); div = 8'd3;
    pulse_start(5, 1'b0);
    wait_done("t6_done_timeout", 80);
    step(2);
    check("t6_count", acc_cyc.size(), 6);
    if (acc_cyc.size() >= 6) begin
      for (int i = 1; i < 6; i++) check("t6_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    end
    div = 8'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
